// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one result bit per cycle, LSB first, through a single full adder.
// Define SERIAL_ADDSUB_SUB_EN to honour i_sub; without it the block only adds and i_sub is ignored.

module full_adder1bit (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);
  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_addsub #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_c_out,
  output logic             o_overflow
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, res_reg;
  logic             carry_reg, ovf_reg;
  logic [CW-1:0]    cnt_reg;

  logic [WIDTH-1:0] b_load;
  logic             cin_load;
  logic             fa_s, fa_c;

`ifdef SERIAL_ADDSUB_SUB_EN
  assign b_load   = i_sub ? ~i_b : i_b;
  assign cin_load = i_sub;
`else
  assign b_load   = i_b;
  assign cin_load = i_sub & 1'b0;
`endif

  full_adder1bit u_fa (
    .a     (a_reg[0]),
    .b     (b_reg[0]),
    .c_in  (carry_reg),
    .s     (fa_s),
    .c_out (fa_c)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    o_ready    = 1'b0;
    o_valid    = 1'b0;
    case (state_reg)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_next = RUN;
      end
      RUN: begin
        if (cnt_reg == LAST_BIT) state_next = DONE;
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      ovf_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_valid) begin
            a_reg     <= i_a;
            b_reg     <= b_load;
            res_reg   <= '0;
            carry_reg <= cin_load;
            ovf_reg   <= 1'b0;
            cnt_reg   <= '0;
          end
        end
        RUN: begin
          res_reg   <= {fa_s, res_reg[WIDTH-1:1]};
          a_reg     <= a_reg >> 1;
          b_reg     <= b_reg >> 1;
          carry_reg <= fa_c;
          cnt_reg   <= cnt_reg + 1'b1;
          // Overflow is the carry into the MSB differing from the carry out of it.
          if (cnt_reg == LAST_BIT) ovf_reg <= carry_reg ^ fa_c;
        end
        default: ;
      endcase
    end
  end

  assign o_sum      = (state_reg == DONE) ? res_reg : '0;
  assign o_c_out    = (state_reg == DONE) ? carry_reg : 1'b0;
  assign o_overflow = (state_reg == DONE) ? ovf_reg : 1'b0;

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal range 2..64).
REQ-002 SHALL have port i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port i_valid  input  1  upstream request valid.
REQ-005 SHALL have port o_ready  output  1  block can accept a request.
REQ-006 SHALL have port i_a  input  WIDTH  operand A.
REQ-007 SHALL have port i_b  input  WIDTH  operand B.
REQ-008 SHALL have port i_sub  input  1  1 = A-B, 0 = A+B.
REQ-009 SHALL have port o_valid  output  1  result valid.
REQ-010 SHALL have port i_ready  input  1  downstream accepts result.
REQ-011 SHALL have port o_sum  output  WIDTH  result.
REQ-012 SHALL have port o_c_out  output  1  carry out of MSB (subtract: 1 = no borrow).
REQ-013 SHALL have port o_overflow  output  1  signed two's-complement overflow.

Function
REQ-014 SHALL compute one result bit per cycle, LSB first, through exactly one full_adder1bit instance; no WIDTH-bit parallel adder permitted.
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; IDLE is the reset state.
REQ-016 IDLE: o_ready=1, o_valid=0; on i_valid&o_ready, SHALL latch i_a, B' = i_sub ? ~i_b : i_b, carry register = i_sub, bit counter = 0, go to RUN.
REQ-017 RUN: o_ready=0, o_valid=0; each cycle SHALL add operand LSBs plus carry register, shift sum bit into result MSB (result shifts right), shift operands right, store carry out, increment counter.
REQ-018 RUN SHALL last exactly WIDTH cycles; on the edge processing bit WIDTH-1 SHALL go to DONE.
REQ-019 o_valid SHALL first be high in the cycle after the WIDTH-th RUN edge, i.e. WIDTH cycles after the accepting edge.
REQ-020 DONE: o_valid=1, o_ready=0; o_sum, o_c_out, o_overflow SHALL hold stable until i_ready=1; i_valid ignored.
REQ-021 On o_valid&i_ready SHALL go to IDLE; o_ready high the following cycle (no same-cycle accept; max throughput one op per WIDTH+2 cycles).
REQ-022 o_c_out SHALL be the carry out of bit WIDTH-1; o_overflow SHALL be carry-in XOR carry-out of bit WIDTH-1.
REQ-023 Result arithmetic SHALL be modulo 2^WIDTH; no saturation.
REQ-024 Input changes while not in IDLE SHALL have no effect on the in-flight result.
REQ-025 o_sum, o_c_out, o_overflow SHALL read 0 in IDLE and RUN.

Reset
REQ-026 With i_rst_n=0 at a rising edge, SHALL enter IDLE and clear operands, result, carry, counter.
REQ-027 After reset: o_ready=1, o_valid=0, o_sum=0, o_c_out=0, o_overflow=0.
REQ-028 Reset during RUN or DONE SHALL discard the operation; no o_valid for it afterwards.
REQ-029 Reset SHALL dominate a simultaneous accept or result handshake.

Configuration
REQ-030 Macro SERIAL_ADDSUB_SUB_EN defined: i_sub honoured per REQ-016.
REQ-031 Macro SERIAL_ADDSUB_SUB_EN undefined: i_sub ignored, B' = i_b, initial carry 0; add only; port list unchanged.

Verification
REQ-032 WIDTH=32, add A=0x00000005, B=0x00000003 -> o_sum=0x00000008, c_out=0, ovf=0, o_valid exactly 32 cycles after accept.
REQ-033 Add A=0xFFFFFFFF, B=0x00000001 -> o_sum=0x00000000, c_out=1, ovf=0; add A=0x7FFFFFFF, B=0x00000001 -> o_sum=0x80000000, c_out=0, ovf=1.
REQ-034 SUB_EN defined: sub A=3, B=5 -> o_sum=0xFFFFFFFE, c_out=0; sub A=5, B=3 -> o_sum=0x00000002, c_out=1; SUB_EN undefined: sub A=5, B=3 -> o_sum=0x00000008.
REQ-035 Hold i_ready=0 for 10 cycles in DONE with i_valid=1 and toggling operands -> outputs stable, o_ready=0, no new accept; i_ready=1 -> IDLE next cycle.
REQ-036 Assert i_rst_n=0 for one edge at RUN bit 10 -> next cycle o_valid=0, o_ready=1, outputs 0; following add 0x12345678+0x11111111 -> 0x23456789.
